// File: rtl/accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accum_pkg
// Description : Shared definitions for the 4-bit add/subtract accumulator and
//               its downstream result FIFO.
//               ACC_WIDTH      - accumulator result width
//               acc_result_t   - packed {of, r} result record
//               ACC_FIFO_DEPTH - default result FIFO depth
// Revision    : 1.0 - initial release
// ============================================================================
package accum_pkg;

    localparam int ACC_WIDTH      = 4;
    localparam int ACC_FIFO_DEPTH = 4;

    typedef struct packed {
        logic                 of;
        logic [ACC_WIDTH-1:0] r;
    } acc_result_t;

endpackage : accum_pkg
`default_nettype wire

// File: rtl/accum_of_counter.sv
`default_nettype none
// ============================================================================
// Module      : accum_of_counter
// Description : Overflow event counter plus sticky overflow flag.
//               Counts every accepted push that carries an overflow flag.
//               A clear coinciding with a counted push leaves count=1 and
//               sticky=1 so that event is never lost.
//               Build option ACCUM_FIFO_OFSAT_EN: counter saturates at its
//               top value instead of wrapping to zero.
// Ports       : clk      - clock, rising edge
//               rst      - synchronous active-high reset
//               i_inc    - count one overflow event this cycle
//               i_clr    - clear counter and sticky flag
//               o_count  - overflow event count
//               o_sticky - set by the first counted event
// Revision    : 1.0 - initial release
// ============================================================================
module accum_of_counter #(
    parameter int OFCNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_inc,
    input  logic               i_clr,
    output logic [OFCNT_W-1:0] o_count,
    output logic               o_sticky
);

    localparam logic [OFCNT_W-1:0] c_cnt_one = OFCNT_W'(1);
    localparam logic [OFCNT_W-1:0] c_cnt_max = '1;

    logic [OFCNT_W-1:0] r_count;
    logic               r_sticky;
    logic [OFCNT_W-1:0] w_count_inc;

`ifdef ACCUM_FIFO_OFSAT_EN
    // Hold at the top value once reached.
    assign w_count_inc = (r_count == c_cnt_max) ? c_cnt_max : (r_count + c_cnt_one);
`else
    // Natural modulo-2^OFCNT_W wrap.
    assign w_count_inc = r_count + c_cnt_one;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (i_clr && i_inc) begin
            // Clear first, then count the coincident event.
            r_count  <= c_cnt_one;
            r_sticky <= 1'b1;
        end else if (i_clr) begin
            r_count  <= '0;
            r_sticky <= 1'b0;
        end else if (i_inc) begin
            r_count  <= w_count_inc;
            r_sticky <= 1'b1;
        end
    end

    assign o_count  = r_count;
    assign o_sticky = r_sticky;

endmodule : accum_of_counter
`default_nettype wire

// File: rtl/accum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : accum_result_fifo
// Description : Result FIFO behind the 4-bit accumulator. Captures {of, r}
//               pairs, releases them over a valid/ready handshake, and keeps
//               overflow statistics (count + sticky flag).
//               Build option ACCUM_FIFO_OFSAT_EN: overflow counter saturates
//               instead of wrapping (implemented in accum_of_counter).
// Ports       : Clk        - clock, rising edge
//               Reset      - synchronous active-high reset
//               in_valid   - upstream result present
//               in_r       - accumulator result
//               in_of      - overflow/borrow flag for in_r
//               in_ready   - FIFO can accept (= !full)
//               out_valid  - head entry valid (= !empty)
//               out_r      - head entry result
//               out_of     - head entry overflow flag
//               out_ready  - consumer takes head entry
//               full/empty - occupancy flags
//               count      - occupied entries
//               of_count   - accepted entries with in_of=1
//               of_sticky  - set on first accepted overflow entry
//               clr_of     - clears of_count and of_sticky
// Revision    : 1.0 - initial release
// ============================================================================
module accum_result_fifo
    import accum_pkg::*;
#(
    parameter int WIDTH   = ACC_WIDTH,
    parameter int DEPTH   = ACC_FIFO_DEPTH,
    parameter int OFCNT_W = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_r,
    input  logic                     in_of,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_r,
    output logic                     out_of,
    input  logic                     out_ready,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [OFCNT_W-1:0]       of_count,
    output logic                     of_sticky,
    input  logic                     clr_of
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [PW-1:0] c_ptr_one   = PW'(1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);
    localparam logic [CW-1:0] c_cnt_depth = CW'(DEPTH);

    logic [WIDTH:0]  r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic            r_full;
    logic            r_empty;

    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;

    // Handshakes qualified only by registered flags, so no combinational
    // path from in_valid/out_ready reaches any flag output.
    assign w_push = in_valid  && !r_full;
    assign w_pop  = out_ready && !r_empty;

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage: clearing every entry on reset makes the head read 0 after
    // reset, which is what downstream sees on out_r/out_of.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wptr] <= {in_of, in_r};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ptr_one;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_cnt_depth);
            r_empty <= (w_count_nxt == '0);
        end
    end

    accum_of_counter #(
        .OFCNT_W (OFCNT_W)
    ) u_of_counter (
        .clk      (Clk),
        .rst      (Reset),
        .i_inc    (w_push && in_of),
        .i_clr    (clr_of),
        .o_count  (of_count),
        .o_sticky (of_sticky)
    );

    assign {out_of, out_r} = r_mem[r_rptr];
    assign full            = r_full;
    assign empty           = r_empty;
    assign in_ready        = !r_full;
    assign out_valid       = !r_empty;
    assign count           = r_count;

endmodule : accum_result_fifo
`default_nettype wire

// File: tb/tb_accum_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_accum_result_fifo
// Description : Directed self-checking bench for accum_result_fifo. A second
//               instance with OFCNT_W=2 shares the stimulus to exercise the
//               overflow counter top value (wrap, or saturation when
//               ACCUM_FIFO_OFSAT_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_result_fifo;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic [3:0] in_r;
    logic       in_of;
    logic       out_ready;
    logic       clr_of;

    logic       in_ready, out_valid, out_of, full, empty, of_sticky;
    logic [3:0] out_r;
    logic [2:0] count;
    logic [7:0] of_count;

    logic       in_ready2, out_valid2, out_of2, full2, empty2, of_sticky2;
    logic [3:0] out_r2;
    logic [2:0] count2;
    logic [1:0] of_count2;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    accum_result_fifo dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_r(in_r), .in_of(in_of),
        .in_ready(in_ready), .out_valid(out_valid), .out_r(out_r), .out_of(out_of),
        .out_ready(out_ready), .full(full), .empty(empty), .count(count),
        .of_count(of_count), .of_sticky(of_sticky), .clr_of(clr_of)
    );

    accum_result_fifo #(.OFCNT_W(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_r(in_r), .in_of(in_of),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_r(out_r2), .out_of(out_of2),
        .out_ready(out_ready), .full(full2), .empty(empty2), .count(count2),
        .of_count(of_count2), .of_sticky(of_sticky2), .clr_of(clr_of)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle before sampling.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; in_valid = 1'b0; in_r = 4'h0; in_of = 1'b0;
        out_ready = 1'b0; clr_of = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        tick();

        // Reset then idle
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_r",     32'(out_r),     32'd0);
        chk("rst_of_count",  32'(of_count),  32'd0);
        chk("rst_of_sticky", 32'(of_sticky), 32'd0);

        // Push 0000/of=1 then 1111/of=0, no pops
        in_valid = 1'b1; in_r = 4'h0; in_of = 1'b1;
        tick();
        chk("p1_out_valid", 32'(out_valid), 32'd1);
        in_r = 4'hF; in_of = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("p2_count",     32'(count),     32'd2);
        chk("p2_out_r",     32'(out_r),     32'h0);
        chk("p2_out_of",    32'(out_of),    32'd1);
        chk("p2_of_count",  32'(of_count),  32'd1);
        chk("p2_of_sticky", 32'(of_sticky), 32'd1);

        // Fill to 4 entries
        in_valid = 1'b1; in_r = 4'h3;
        tick();
        chk("f3_count", 32'(count), 32'd3);
        chk("f3_full",  32'(full),  32'd0);
        in_r = 4'h5;
        tick();
        chk("f4_full",     32'(full),     32'd1);
        chk("f4_in_ready", 32'(in_ready), 32'd0);
        // Keep offering while full; nothing may be accepted
        in_r = 4'hA; in_of = 1'b1;
        tick(); tick(); tick();
        in_valid = 1'b0; in_of = 1'b0;
        chk("full_hold_count", 32'(count),    32'd4);
        chk("full_hold_full",  32'(full),     32'd1);
        chk("full_no_of",      32'(of_count), 32'd1);

        // Drain across the pointer wrap: 0(of), F, 3, 5
        out_ready = 1'b1;
        chk("d0_r", 32'(out_r), 32'h0); chk("d0_of", 32'(out_of), 32'd1);
        tick();
        chk("d1_r", 32'(out_r), 32'hF); chk("d1_of", 32'(out_of), 32'd0);
        chk("d1_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("d2_r", 32'(out_r), 32'h3);
        tick();
        chk("d3_r", 32'(out_r), 32'h5);
        tick();
        chk("drained_empty", 32'(empty),     32'd1);
        chk("drained_valid", 32'(out_valid), 32'd0);
        // Pop attempt while empty must not underflow
        tick();
        chk("empty_pop_count", 32'(count), 32'd0);
        chk("empty_pop_empty", 32'(empty), 32'd1);
        out_ready = 1'b0;

        // Simultaneous push/pop at count=2
        in_valid = 1'b1; in_r = 4'h1;
        tick();
        in_r = 4'h2;
        tick();
        chk("pp_pre_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_r = 4'(3 + i);
            chk($sformatf("pp%0d_head", i), 32'(out_r), 32'(i + 1));
            tick();
            chk($sformatf("pp%0d_count", i), 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        chk("pp_tail0", 32'(out_r), 32'h7);
        tick();
        chk("pp_tail1", 32'(out_r), 32'h8);
        tick();
        out_ready = 1'b0;
        chk("pp_end_empty", 32'(empty), 32'd1);

        // clr_of coinciding with a counted push keeps the event
        in_valid = 1'b1; in_r = 4'h9; in_of = 1'b1; clr_of = 1'b1;
        tick();
        chk("clr_push_cnt",    32'(of_count),  32'd1);
        chk("clr_push_sticky", 32'(of_sticky), 32'd1);
        chk("clr_push_cnt2",   32'(of_count2), 32'd1);
        in_valid = 1'b0; in_of = 1'b0;
        tick();
        clr_of = 1'b0;
        chk("clr_only_cnt",    32'(of_count),  32'd0);
        chk("clr_only_sticky", 32'(of_sticky), 32'd0);
        chk("clr_head",        32'(out_r),     32'h9);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("clr_drained", 32'(empty), 32'd1);

        // Five overflow pushes with continuous pops
        out_ready = 1'b1; in_valid = 1'b1; in_of = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_r = 4'(i);
            tick();
        end
        out_ready = 1'b0; in_of = 1'b0;
        chk("ov5_count",  32'(count),    32'd1);
        chk("ov5_of_cnt", 32'(of_count), 32'd5);
`ifdef ACCUM_FIFO_OFSAT_EN
        chk("ov5_of_cnt_w2", 32'(of_count2), 32'd3);
`else
        chk("ov5_of_cnt_w2", 32'(of_count2), 32'd1);
`endif
        chk("ov5_sticky_w2", 32'(of_sticky2), 32'd1);

        // Queue 3 entries, then reset mid-stream with traffic offered
        in_r = 4'hB; tick();
        in_r = 4'hC; tick();
        chk("pre_rst_count", 32'(count), 32'd3);
        Reset = 1'b1; out_ready = 1'b1; in_r = 4'hD; in_of = 1'b1;
        tick();
        Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_of = 1'b0;
        chk("mrst_count",     32'(count),     32'd0);
        chk("mrst_empty",     32'(empty),     32'd1);
        chk("mrst_full",      32'(full),      32'd0);
        chk("mrst_in_ready",  32'(in_ready),  32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_r",     32'(out_r),     32'd0);
        chk("mrst_out_of",    32'(out_of),    32'd0);
        chk("mrst_of_count",  32'(of_count),  32'd0);
        chk("mrst_of_sticky", 32'(of_sticky), 32'd0);
        chk("mrst_of_cnt2",   32'(of_count2), 32'd0);

        // FIFO works normally after the reset
        in_valid = 1'b1; in_r = 4'h6;
        tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_r",     32'(out_r),     32'h6);
        chk("post_rst_count", 32'(count),     32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_accum_result_fifo
`default_nettype wire

// File: doc/accum_result_fifo.md
# accum_result_fifo

Downstream stage of the 4-bit add/subtract accumulator. It captures each accumulator result `r` and its overflow flag `of` into a small FIFO, and releases them to the consumer over a valid/ready handshake. It also keeps a running count of overflowed results and a sticky overflow flag for the status logic. All state is clocked on `Clk`.

## Interface
- `WIDTH`, default 4: result width; matches accumulator `r`.
- `DEPTH`, default 4: FIFO entries; must be a power of two, ≥2.
- `OFCNT_W`, default 8: overflow counter width.
- `Clk`  in  1: single clock; all state updates on rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: upstream result present this cycle.
- `in_r`  in  WIDTH: accumulator result.
- `in_of`  in  1: accumulator overflow/borrow flag for `in_r`.
- `in_ready`  out  1: FIFO can accept an entry; equals `!full`.
- `out_valid`  out  1: head entry valid; equals `!empty`.
- `out_r`  out  WIDTH: head entry result.
- `out_of`  out  1: head entry overflow flag.
- `out_ready`  in  1: consumer takes the head entry this cycle.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `count`  out  $clog2(DEPTH)+1: number of occupied entries.
- `of_count`  out  OFCNT_W: number of accepted entries with `in_of`=1.
- `of_sticky`  out  1: set on the first accepted overflow entry.
- `clr_of`  in  1: clears `of_count` and `of_sticky`.

## Operation
- Storage: DEPTH × (WIDTH+1) entries holding {of, r}; write and read pointers of width $clog2(DEPTH), wrapping modulo DEPTH; separate occupancy counter.
- Push = `in_valid && in_ready`. Writes the entry at wptr and increments wptr.
- Pop = `out_valid && out_ready`. Increments rptr.
- `out_r`/`out_of` always show mem[rptr]. When `empty`, they hold their last value and are don't-care to the consumer.
- Count: push only → +1; pop only → −1; push and pop together → unchanged.
- Full: `in_ready`=0, so no push is accepted. A pop in the same cycle does not admit a push; `in_ready` rises the cycle after the pop.
- Empty: no pop, whatever `out_ready` is. A push while empty makes the entry visible the next cycle; there is no same-cycle bypass.
- Overflow accounting, evaluated only on accepted pushes with `in_of`=1:
  - `of_count` increments; `of_sticky` is set.
  - When `clr_of` and a counted push coincide, the result is `of_count`=1 and `of_sticky`=1, so the event is not lost.
  - `clr_of` alone gives `of_count`=0 and `of_sticky`=0.
  - Counter wrap/saturation at the top value: see Configuration.
- Reset, with `Reset` high at the edge:
  - wptr, rptr and count go to 0; `empty`=1, `full`=0, `out_valid`=0, `in_ready`=1.
  - `out_r`=0 and `out_of`=0, because memory entry 0 is cleared.
  - `of_count`=0 and `of_sticky`=0.
  - Pushes and pops in that cycle are ignored.
  - A reset mid-stream discards all entries.

## Timing
- Push→visible latency: 1 cycle. An entry pushed at edge N drives `out_valid`/`out_r` after edge N, provided it is the head.
- Throughput: 1 push and 1 pop per cycle.
- Flags (`full`, `empty`, `count`, `in_ready`, `out_valid`) come from registers, not from combinational paths through `in_valid`/`out_ready`.
- `of_count`/`of_sticky` update at the same edge as the push that causes them.

## Configuration
- `ACCUM_FIFO_OFSAT_EN` defined: `of_count` saturates at 2^OFCNT_W−1. Further counted pushes leave it there; `of_sticky` stays 1.
- Not defined: `of_count` wraps to 0 after 2^OFCNT_W−1; `of_sticky` stays 1.

## Structure
- Shared package `accum_pkg`:
  - `ACC_WIDTH`=4.
  - Typedef `acc_result_t` = packed {of, r[3:0]}.
  - Constant `ACC_FIFO_DEPTH`=4.
- One natural sub-module: `accum_of_counter`, which holds `of_count` and `of_sticky` and contains the saturation macro logic. Storage, pointers and flags stay in the top module.

## Test plan
- Reset then idle: `count`=0, `empty`=1, `in_ready`=1, `out_valid`=0, `of_count`=0.
- Push 0000/of=1 (1111+0001), then 1111/of=0 (1010+0101), with `out_ready`=0:
  - after 2 edges, `count`=2 and `out_r`=0000, `out_of`=1;
  - `of_count`=1, `of_sticky`=1.
- Fill to 4 entries, hold `in_valid`=1 for 3 extra cycles:
  - `full`=1, `in_ready`=0, count stays 4, no entry is overwritten;
  - drain with `out_ready`=1 and check order is preserved across pointer wrap.
- At count=2, push and pop in the same cycle for 6 cycles: count stays 2, and the outputs follow push order with 2-entry delay.
- Pulse `clr_of` in the same cycle as a push with `in_of`=1: `of_count`=1 afterwards; then `clr_of` alone gives 0.
- With `OFCNT_W`=2, apply 5 overflow pushes: `of_count`=3 with `ACCUM_FIFO_OFSAT_EN` defined, 1 without; assert `Reset` with 3 entries queued and check the full reset state on the next cycle.
